painterengine_gpu_dma_arbiter: RTL and testbench

- Round-robin scheduler that shares one painterengine_gpu_dma engine between PARAM_PORTS requesters, for example the texture fetch, blit source and framebuffer write units.
- Arbitrates requests, latches the command, sequences the DMA through its reset/enable, routes data streams to the granted port, and returns done/error per port.
- Sits between the GPU pipeline units and the DMA/AXI master.

---
 rtl/painterengine_gpu_dma_arbiter_if.sv | 59 +++++
 rtl/painterengine_gpu_dma_arbiter.sv | 156 +++++++++++++++
 tb/tb_painterengine_gpu_dma_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/painterengine_gpu_dma_arbiter_if.sv
// Request/stream bundle between the GPU pipeline units, the DMA arbiter and the DMA engine.
// Names are from the arbiter's side: i_* flow into the arbiter, o_* flow out of it.
interface painterengine_gpu_dma_arbiter_if #(
   parameter int PARAM_PORTS      = 2,
   parameter int PARAM_DATA_WIDTH = 32
);
   logic [PARAM_PORTS-1:0]                  i_wire_req;
   logic [PARAM_PORTS-1:0]                  i_wire_opcode_0r_1w;
   logic [32*PARAM_PORTS-1:0]               i_wire_address;
   logic [32*PARAM_PORTS-1:0]               i_wire_data_size;
   logic [PARAM_DATA_WIDTH*PARAM_PORTS-1:0] i_wire_wdata;
   logic [PARAM_PORTS-1:0]                  i_wire_wdata_valid;
   logic [PARAM_PORTS-1:0]                  o_wire_wdata_next;
   logic [PARAM_DATA_WIDTH-1:0]             o_wire_rdata;
   logic [PARAM_PORTS-1:0]                  o_wire_rdata_valid;
   logic [PARAM_PORTS-1:0]                  i_wire_rdata_next;
   logic [PARAM_PORTS-1:0]                  o_wire_grant;
   logic [PARAM_PORTS-1:0]                  o_wire_done;
   logic [PARAM_PORTS-1:0]                  o_wire_error;

   logic                                    o_wire_dma_resetn;
   logic                                    o_wire_dma_opcode_0r_1w;
   logic [31:0]                             o_wire_dma_address;
   logic [31:0]                             o_wire_dma_data_size;
   logic [PARAM_DATA_WIDTH-1:0]             o_wire_dma_data;
   logic                                    o_wire_dma_data_valid;
   logic                                    i_wire_dma_data_next;
   logic [PARAM_DATA_WIDTH-1:0]             i_wire_dma_data;
   logic                                    i_wire_dma_data_valid;
   logic                                    o_wire_dma_data_next;
   logic                                    i_wire_dma_done;
   logic                                    i_wire_dma_error;

   // Arbiter side.
   modport slave (
      input  i_wire_req, i_wire_opcode_0r_1w, i_wire_address, i_wire_data_size,
      input  i_wire_wdata, i_wire_wdata_valid, i_wire_rdata_next,
      input  i_wire_dma_data_next, i_wire_dma_data, i_wire_dma_data_valid,
      input  i_wire_dma_done, i_wire_dma_error,
      output o_wire_wdata_next, o_wire_rdata, o_wire_rdata_valid,
      output o_wire_grant, o_wire_done, o_wire_error,
      output o_wire_dma_resetn, o_wire_dma_opcode_0r_1w, o_wire_dma_address,
      output o_wire_dma_data_size, o_wire_dma_data, o_wire_dma_data_valid,
      output o_wire_dma_data_next
   );

   // Requesters plus DMA engine side.
   modport master (
      output i_wire_req, i_wire_opcode_0r_1w, i_wire_address, i_wire_data_size,
      output i_wire_wdata, i_wire_wdata_valid, i_wire_rdata_next,
      output i_wire_dma_data_next, i_wire_dma_data, i_wire_dma_data_valid,
      output i_wire_dma_done, i_wire_dma_error,
      input  o_wire_wdata_next, o_wire_rdata, o_wire_rdata_valid,
      input  o_wire_grant, o_wire_done, o_wire_error,
      input  o_wire_dma_resetn, o_wire_dma_opcode_0r_1w, o_wire_dma_address,
      input  o_wire_dma_data_size, o_wire_dma_data, o_wire_dma_data_valid,
      input  o_wire_dma_data_next
   );
endinterface

// File: rtl/painterengine_gpu_dma_arbiter.sv
// Round-robin owner of one DMA engine: grant, latch command, hold DMA in reset for setup, route streams, pulse done/error.
// Req to DMA release is 1 + PARAM_SETUP_CYCLES cycles; streams pass combinationally to the owner, others see valid/next = 0.
module painterengine_gpu_dma_arbiter #(
   parameter int PARAM_PORTS        = 2,
   parameter int PARAM_DATA_WIDTH   = 32,
   parameter int PARAM_SETUP_CYCLES = 2
) (
   input  logic                          i_wire_clock,
   input  logic                          i_wire_resetn,
   painterengine_gpu_dma_arbiter_if.slave bus
);
   localparam int PW = (PARAM_PORTS > 1) ? $clog2(PARAM_PORTS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_RUN,
      ST_FINISH
   } state_t;

   state_t                 state, state_nxt;
   logic [PW-1:0]          ptr, ptr_nxt;
   logic [PW-1:0]          owner, owner_nxt;
   logic [PARAM_PORTS-1:0] grant, grant_nxt;
   logic                   cmd_op, cmd_op_nxt;
   logic [31:0]            cmd_addr, cmd_addr_nxt;
   logic [31:0]            cmd_size, cmd_size_nxt;
   logic [3:0]             setup_cnt, setup_cnt_nxt;
   logic                   err, err_nxt;

   logic                   win_found;
   logic [PW-1:0]          win_idx;

   // First requester strictly after the last winner, wrapping around.
   always_comb begin
      int cand;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int i = 1; i <= PARAM_PORTS; i++) begin
         cand = int'(ptr) + i;
         if (cand >= PARAM_PORTS) cand = cand - PARAM_PORTS;
         if (!win_found && bus.i_wire_req[cand]) begin
            win_found = 1'b1;
            win_idx   = PW'(cand);
         end
      end
   end

   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         state     <= ST_IDLE;
         ptr       <= PW'(PARAM_PORTS - 1);
         owner     <= '0;
         grant     <= '0;
         cmd_op    <= 1'b0;
         cmd_addr  <= '0;
         cmd_size  <= '0;
         setup_cnt <= '0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         owner     <= owner_nxt;
         grant     <= grant_nxt;
         cmd_op    <= cmd_op_nxt;
         cmd_addr  <= cmd_addr_nxt;
         cmd_size  <= cmd_size_nxt;
         setup_cnt <= setup_cnt_nxt;
         err       <= err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      owner_nxt     = owner;
      grant_nxt     = grant;
      cmd_op_nxt    = cmd_op;
      cmd_addr_nxt  = cmd_addr;
      cmd_size_nxt  = cmd_size;
      setup_cnt_nxt = setup_cnt;
      err_nxt       = err;
      case (state)
         ST_IDLE: begin
            if (win_found) begin
               grant_nxt          = '0;
               grant_nxt[win_idx] = 1'b1;
               owner_nxt          = win_idx;
               ptr_nxt            = win_idx;
               cmd_op_nxt         = bus.i_wire_opcode_0r_1w[win_idx];
               cmd_addr_nxt       = bus.i_wire_address[int'(win_idx)*32 +: 32];
               cmd_size_nxt       = bus.i_wire_data_size[int'(win_idx)*32 +: 32];
               setup_cnt_nxt      = '0;
               err_nxt            = 1'b0;
               state_nxt          = ST_SETUP;
            end
         end
         ST_SETUP: begin
            // The zero-length check uses the latched size, so an empty job finishes one cycle after the grant.
            if (cmd_size == 32'd0) begin
               state_nxt = ST_FINISH;
            end else if (setup_cnt == 4'(PARAM_SETUP_CYCLES - 1)) begin
               state_nxt = ST_RUN;
            end else begin
               setup_cnt_nxt = setup_cnt + 4'd1;
            end
         end
         ST_RUN: begin
            if (bus.i_wire_dma_done || bus.i_wire_dma_error) begin
               err_nxt   = bus.i_wire_dma_error;
               state_nxt = ST_FINISH;
            end
         end
         ST_FINISH: begin
            grant_nxt = '0;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.o_wire_grant            = grant;
   assign bus.o_wire_dma_opcode_0r_1w = cmd_op;
   assign bus.o_wire_dma_address      = cmd_addr;
   assign bus.o_wire_dma_data_size    = cmd_size;

   // Everything below is derived from state alone, so an async reset zeroes it at once.
   always_comb begin
      bus.o_wire_dma_resetn     = 1'b0;
      bus.o_wire_dma_data       = '0;
      bus.o_wire_dma_data_valid = 1'b0;
      bus.o_wire_wdata_next     = '0;
      bus.o_wire_rdata          = '0;
      bus.o_wire_rdata_valid    = '0;
      bus.o_wire_dma_data_next  = 1'b0;
      bus.o_wire_done           = '0;
      bus.o_wire_error          = '0;
      case (state)
         ST_RUN: begin
            bus.o_wire_dma_resetn        = 1'b1;
            bus.o_wire_dma_data          = bus.i_wire_wdata[int'(owner)*PARAM_DATA_WIDTH +: PARAM_DATA_WIDTH];
            bus.o_wire_dma_data_valid    = bus.i_wire_wdata_valid[owner];
            bus.o_wire_wdata_next[owner] = bus.i_wire_dma_data_next;
            bus.o_wire_rdata             = bus.i_wire_dma_data;
            bus.o_wire_rdata_valid[owner] = bus.i_wire_dma_data_valid;
            bus.o_wire_dma_data_next     = bus.i_wire_rdata_next[owner];
         end
         ST_FINISH: begin
            bus.o_wire_done  = grant;
            bus.o_wire_error = err ? grant : '0;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_painterengine_gpu_dma_arbiter.sv
// Directed bench for the DMA arbiter: hand-sequenced jobs plus a routing table applied while port 1 owns the DMA.
module tb_painterengine_gpu_dma_arbiter;
   localparam int PORTS = 2;
   localparam int DW    = 32;
   localparam int SETUP = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests  = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   painterengine_gpu_dma_arbiter_if #(.PARAM_PORTS(PORTS), .PARAM_DATA_WIDTH(DW)) bus ();

   painterengine_gpu_dma_arbiter #(
      .PARAM_PORTS(PORTS), .PARAM_DATA_WIDTH(DW), .PARAM_SETUP_CYCLES(SETUP)
   ) dut (
      .i_wire_clock (clk),
      .i_wire_resetn(rst_n),
      .bus          (bus)
   );

   typedef struct {
      logic [1:0]  wvld;
      logic        dnext;
      logic [31:0] wd1;
      logic        rvld;
      logic [1:0]  rnext;
      logic        exp_vld;
      logic [1:0]  exp_wnext;
      logic [1:0]  exp_rvalid;
      logic        exp_dnext;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      logic [1:0] exp_g;
      int n;

      vecs[0] = '{2'b11, 1'b1, 32'hA000_0001, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0};
      vecs[1] = '{2'b01, 1'b1, 32'hA000_0002, 1'b0, 2'b11, 1'b0, 2'b10, 2'b00, 1'b1};
      vecs[2] = '{2'b11, 1'b0, 32'hA000_0002, 1'b1, 2'b01, 1'b1, 2'b00, 2'b10, 1'b0};
      vecs[3] = '{2'b10, 1'b0, 32'hA000_0003, 1'b1, 2'b10, 1'b1, 2'b00, 2'b10, 1'b1};
      vecs[4] = '{2'b10, 1'b1, 32'hA000_0003, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0};
      vecs[5] = '{2'b00, 1'b1, 32'hA000_0004, 1'b1, 2'b11, 1'b0, 2'b10, 2'b10, 1'b1};
      vecs[6] = '{2'b11, 1'b1, 32'hA000_0004, 1'b0, 2'b01, 1'b1, 2'b10, 2'b00, 1'b0};
      vecs[7] = '{2'b01, 1'b0, 32'hA000_0005, 1'b1, 2'b00, 1'b0, 2'b00, 2'b10, 1'b0};

      bus.i_wire_req            = '0;
      bus.i_wire_opcode_0r_1w   = '0;
      bus.i_wire_address        = '0;
      bus.i_wire_data_size      = '0;
      bus.i_wire_wdata          = '0;
      bus.i_wire_wdata_valid    = '0;
      bus.i_wire_rdata_next     = '0;
      bus.i_wire_dma_data_next  = 1'b0;
      bus.i_wire_dma_data       = '0;
      bus.i_wire_dma_data_valid = 1'b0;
      bus.i_wire_dma_done       = 1'b0;
      bus.i_wire_dma_error      = 1'b0;

      // Reset state
      cyc();
      check("rst_grant", bus.o_wire_grant, 0);
      check("rst_dma_resetn", bus.o_wire_dma_resetn, 0);
      check("rst_done", bus.o_wire_done, 0);
      check("rst_dma_addr", bus.o_wire_dma_address, 0);
      rst_n = 1'b1;
      cyc();

      // Port 0 read of 16 bytes, 4 words streamed back
      bus.i_wire_address   = {32'h0000_2000, 32'h0000_1000};
      bus.i_wire_data_size = {32'd0, 32'd16};
      bus.i_wire_req       = 2'b01;
      cyc();
      check("rd_grant", bus.o_wire_grant, 2'b01);
      check("rd_cmd_addr", bus.o_wire_dma_address, 32'h1000);
      check("rd_cmd_size", bus.o_wire_dma_data_size, 16);
      check("rd_resetn_c1", bus.o_wire_dma_resetn, 0);
      cyc();
      check("rd_resetn_c2", bus.o_wire_dma_resetn, 0);
      cyc();
      check("rd_resetn_c3", bus.o_wire_dma_resetn, 1);
      for (int w = 0; w < 4; w++) begin
         bus.i_wire_dma_data       = 32'hC0DE_0000 + w;
         bus.i_wire_dma_data_valid = 1'b1;
         bus.i_wire_rdata_next     = 2'b11;
         #1;
         check("rd_word", bus.o_wire_rdata, 32'hC0DE_0000 + w);
         check("rd_rvalid", bus.o_wire_rdata_valid, 2'b01);
         check("rd_dnext", bus.o_wire_dma_data_next, 1);
         cyc();
      end
      bus.i_wire_dma_data_valid = 1'b0;
      bus.i_wire_rdata_next     = 2'b00;
      bus.i_wire_dma_done       = 1'b1;
      cyc();
      bus.i_wire_dma_done = 1'b0;
      bus.i_wire_req      = 2'b00;
      check("rd_done", bus.o_wire_done, 2'b01);
      check("rd_error", bus.o_wire_error, 2'b00);
      check("rd_fin_resetn", bus.o_wire_dma_resetn, 0);
      cyc();
      check("rd_done_once", bus.o_wire_done, 2'b00);
      check("rd_grant_clr", bus.o_wire_grant, 2'b00);

      // Zero-length job on port 0
      bus.i_wire_data_size = {32'd8, 32'd0};
      bus.i_wire_req       = 2'b01;
      cyc();
      check("z_done_c1", bus.o_wire_done, 2'b00);
      check("z_resetn_c1", bus.o_wire_dma_resetn, 0);
      cyc();
      check("z_done_c2", bus.o_wire_done, 2'b01);
      check("z_error_c2", bus.o_wire_error, 2'b00);
      check("z_resetn_c2", bus.o_wire_dma_resetn, 0);
      bus.i_wire_req = 2'b00;
      cyc();
      check("z_resetn_c3", bus.o_wire_dma_resetn, 0);

      // Port 1: done and error in the same cycle
      bus.i_wire_data_size    = {32'd4, 32'd0};
      bus.i_wire_opcode_0r_1w = 2'b10;
      bus.i_wire_req          = 2'b10;
      cyc(); cyc(); cyc();
      check("err_resetn", bus.o_wire_dma_resetn, 1);
      bus.i_wire_dma_done  = 1'b1;
      bus.i_wire_dma_error = 1'b1;
      cyc();
      bus.i_wire_dma_done  = 1'b0;
      bus.i_wire_dma_error = 1'b0;
      bus.i_wire_req       = 2'b00;
      check("err_done", bus.o_wire_done, 2'b10);
      check("err_error", bus.o_wire_error, 2'b10);
      cyc();
      check("err_clr", bus.o_wire_error, 2'b00);

      // Port 1 write of 8 bytes, routing table
      bus.i_wire_data_size = {32'd8, 32'd0};
      bus.i_wire_req       = 2'b10;
      cyc(); cyc(); cyc();
      check("wr_grant", bus.o_wire_grant, 2'b10);
      check("wr_cmd_op", bus.o_wire_dma_opcode_0r_1w, 1);
      check("wr_cmd_size", bus.o_wire_dma_data_size, 8);
      check("wr_resetn", bus.o_wire_dma_resetn, 1);
      for (int i = 0; i < 8; i++) begin
         bus.i_wire_wdata          = {vecs[i].wd1, 32'hDEAD_0000};
         bus.i_wire_wdata_valid    = vecs[i].wvld;
         bus.i_wire_dma_data_next  = vecs[i].dnext;
         bus.i_wire_dma_data       = 32'h5A5A_0000 + i;
         bus.i_wire_dma_data_valid = vecs[i].rvld;
         bus.i_wire_rdata_next     = vecs[i].rnext;
         #1;
         check("tbl_wdata", bus.o_wire_dma_data, vecs[i].wd1);
         check("tbl_wvalid", bus.o_wire_dma_data_valid, vecs[i].exp_vld);
         check("tbl_wnext", bus.o_wire_wdata_next, vecs[i].exp_wnext);
         check("tbl_rvalid", bus.o_wire_rdata_valid, vecs[i].exp_rvalid);
         check("tbl_dnext", bus.o_wire_dma_data_next, vecs[i].exp_dnext);
         check("tbl_rdata", bus.o_wire_rdata, 32'h5A5A_0000 + i);
         cyc();
      end
      bus.i_wire_wdata_valid    = '0;
      bus.i_wire_dma_data_next  = 1'b0;
      bus.i_wire_dma_data_valid = 1'b0;
      bus.i_wire_rdata_next     = '0;
      bus.i_wire_dma_done       = 1'b1;
      cyc();
      bus.i_wire_dma_done = 1'b0;
      bus.i_wire_req      = 2'b00;
      check("wr_done", bus.o_wire_done, 2'b10);
      check("wr_error", bus.o_wire_error, 2'b00);
      check("wr_fin_wnext", bus.o_wire_wdata_next, 2'b00);
      cyc();

      // Ports 0 and 1 held together: 0,1,0,1 with an idle gap between jobs
      bus.i_wire_opcode_0r_1w = 2'b00;
      bus.i_wire_data_size    = {32'd4, 32'd4};
      bus.i_wire_req          = 2'b11;
      exp_g = 2'b01;
      for (int j = 0; j < 4; j++) begin
         n = 0;
         while (bus.o_wire_grant == 2'b00 && n < 20) begin cyc(); n++; end
         check("rr_grant", bus.o_wire_grant, exp_g);
         n = 0;
         while (!bus.o_wire_dma_resetn && n < 20) begin cyc(); n++; end
         check("rr_release", bus.o_wire_dma_resetn, 1);
         bus.i_wire_dma_done = 1'b1;
         cyc();
         bus.i_wire_dma_done = 1'b0;
         check("rr_done", bus.o_wire_done, exp_g);
         cyc();
         check("rr_gap", bus.o_wire_grant, 2'b00);
         exp_g = ~exp_g;
      end
      bus.i_wire_req = 2'b00;
      cyc();

      // Reset in RUN, then fresh contention goes to port 0
      bus.i_wire_address   = {32'h0000_2000, 32'h0000_3000};
      bus.i_wire_data_size = {32'd16, 32'd16};
      bus.i_wire_req       = 2'b01;
      cyc(); cyc(); cyc();
      bus.i_wire_dma_data_valid = 1'b1;
      #1;
      check("mr_rvalid_run", bus.o_wire_rdata_valid, 2'b01);
      rst_n = 1'b0;
      bus.i_wire_req = 2'b11;
      #1;
      check("mr_grant", bus.o_wire_grant, 2'b00);
      check("mr_resetn", bus.o_wire_dma_resetn, 0);
      check("mr_rvalid", bus.o_wire_rdata_valid, 2'b00);
      check("mr_addr", bus.o_wire_dma_address, 0);
      cyc();
      check("mr_no_done", bus.o_wire_done, 2'b00);
      bus.i_wire_dma_data_valid = 1'b0;
      rst_n = 1'b1;
      cyc();
      check("mr_regrant", bus.o_wire_grant, 2'b01);
      check("mr_regrant_addr", bus.o_wire_dma_address, 32'h3000);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
